vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Free-running SVGA raster timing generator; upstream of every gen-layer (move box, camera, text).
//  Produces active-area pixel coordinates (h_c, v_c) with per-pixel strobe h_c_en for the layers.
//  Produces hsync/vsync/de, delayed by PIPE_LAT clocks to align with registered layer RGB output.
//  Default raster: 800x600@60, 40 MHz pixel rate.
// PARAMETERS
//  H_ACTIVE 800  visible pixels/line (<=1024)
//  H_FP     40   horizontal front porch, pixels
//  H_SYNC   128  hsync width, pixels
//  H_BP     88   horizontal back porch; H_TOTAL=sum=1056 (<=2047)
//  V_ACTIVE 600  visible lines (<=1024)
//  V_FP     1    vertical front porch, lines
//  V_SYNC   4    vsync width, lines
//  V_BP     23   vertical back porch; V_TOTAL=sum=628 (<=2047)
//  HS_POL   1    hsync active level
//  VS_POL   1    vsync active level
//  CLK_DIV  1    clk cycles per pixel (1..16)
//  PIPE_LAT 1    delay of hsync/vsync/de vs h_c/v_c, clocks (0..7)
// PORTS
//  clk          in   1   system clock, all logic rising edge
//  rst          in   1   synchronous reset, active high
//  run          in   1   1 = raster advances; 0 = freeze
//  h_c_en       out  1   one-clk strobe per active pixel
//  h_c          out  10  active x, 0..H_ACTIVE-1; 0 outside horizontal active
//  v_c          out  10  active y, 0..V_ACTIVE-1; 0 outside vertical active
//  frame_start  out  1   one-clk pulse, pixel period of (0,0) begins
//  frame_end    out  1   one-clk pulse, coincident with h_c_en at last active pixel
//  hsync_o      out  1   delayed hsync, level per HS_POL
//  vsync_o      out  1   delayed vsync, level per VS_POL
//  de_o         out  1   delayed data enable (active pixel)
// BEHAVIOUR
//  - Clock/reset: one clock; reset synchronous active-high; all flops reset on rst=1 at clk edge; rst overrides run.
//  - State: div_cnt (4b), hcnt (11b, 0..H_TOTAL-1), vcnt (11b, 0..V_TOTAL-1); all registered outputs.
//  - tick = run & (div_cnt==CLK_DIV-1). div_cnt counts only while run=1, wraps to 0 on tick.
//  - On tick: hcnt++. When hcnt==H_TOTAL-1, hcnt->0 and vcnt++. When vcnt==V_TOTAL-1 also, vcnt->0.
//  - Regions per counter, in order: active [0,ACT), FP, SYNC, BP.
//    - hsync active for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); 840..967 at defaults.
//    - vsync likewise on vcnt; 601..604 at defaults.
//  - active = hcnt<H_ACTIVE & vcnt<V_ACTIVE.
//  - h_c/v_c reflect current counters, hold for the whole pixel period. h_c_en = tick & active.
//    - CLK_DIV=1: h_c_en high continuously across the 800 active clocks of a line.
//  - frame_start = tick-qualified first clk of period with hcnt=0,vcnt=0.
//  - frame_end = h_c_en & h_c==H_ACTIVE-1 & v_c==V_ACTIVE-1; exactly once per frame.
//  - hsync/vsync/de computed from counters each clk, passed through PIPE_LAT-deep shift register.
//    - de_raw = active & (CLK_DIV==1 ? 1 : tick).
//    - PIPE_LAT=0 gives a direct path.
//  - run=0: counters/div_cnt frozen; h_c_en, frame_start, frame_end forced 0.
//    - Sync levels continue from frozen counters; de_raw=0.
//    - run 0->1 resumes at the frozen position with no skipped or repeated pixels.
//  - Reset values:
//    - counters 0; h_c=0, v_c=0; h_c_en=0; frame_start=0; frame_end=0.
//    - hsync_o=~HS_POL, vsync_o=~VS_POL, de_o=0; whole delay line cleared to these levels.
//  - First tick after reset is pixel (0,0).
//  - Reset mid-frame: next cycle matches post-reset state exactly; no partial-line output.
// TESTING
//  1. rst 3 clks, run=1, defaults -> all outputs at reset values during rst; first h_c_en with h_c=0,v_c=0, frame_start=1.
//  2. Run 2 frames -> 480000 h_c_en per frame; frame_end period 663168 clks; exactly 1 frame_end at (799,599).
//  3. Line scan -> hsync_o high 128 clks starting 840+1 clks after line start; vsync_o high 4 lines (601..604), +1 clk.
//  4. CLK_DIV=2 -> h_c_en every 2nd clk; h_c held 2 clks each; frame period 1326336 clks.
//  5. Drop run at h_c=400 for 50 clks -> no h_c_en, h_c stays 400; resume, next strobe h_c=400 then 401.
//  6. Assert rst at v_c=300 -> next clk outputs at reset values, then restart at (0,0); de_o lags h_c_en by 1 clk.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator: pixel coordinates and strobes for the gen-layers,
// plus sync/de delayed to line up with registered layer RGB.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter int unsigned HS_POL   = 1,
    parameter int unsigned VS_POL   = 1,
    parameter int unsigned CLK_DIV  = 1,
    parameter int unsigned PIPE_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       h_c_en,
    output logic [9:0] h_c,
    output logic [9:0] v_c,
    output logic       frame_start,
    output logic       frame_end,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       de_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0]  L_DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [10:0] L_H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] L_V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] L_H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] L_V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] L_H_XLAST  = 11'(H_ACTIVE - 1);
    localparam logic [10:0] L_V_YLAST  = 11'(V_ACTIVE - 1);
    localparam logic [10:0] L_HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] L_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] L_VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] L_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        L_HS_ON    = (HS_POL != 0);
    localparam logic        L_VS_ON    = (VS_POL != 0);
    localparam logic [2:0]  L_IDLE     = {~L_HS_ON, ~L_VS_ON, 1'b0};

    logic [3:0]  r_div_cnt;
    logic [10:0] r_hcnt;
    logic [10:0] r_vcnt;

    logic r_h_c_en;
    logic [9:0] r_h_c;
    logic [9:0] r_v_c;
    logic r_frame_start;
    logic r_frame_end;
    logic r_hs_raw;
    logic r_vs_raw;
    logic r_de_raw;

    logic w_tick;
    logic w_h_act;
    logic w_v_act;
    logic w_active;
    logic w_h_c_en;
    logic w_hs;
    logic w_vs;
    logic w_de;

    always_comb begin
        w_tick   = run & (r_div_cnt == L_DIV_LAST);
        w_h_act  = (r_hcnt < L_H_ACT);
        w_v_act  = (r_vcnt < L_V_ACT);
        w_active = w_h_act & w_v_act;
        w_h_c_en = w_tick & w_active;
        w_hs     = ((r_hcnt >= L_HS_BEG) && (r_hcnt < L_HS_END)) ? L_HS_ON : ~L_HS_ON;
        w_vs     = ((r_vcnt >= L_VS_BEG) && (r_vcnt < L_VS_END)) ? L_VS_ON : ~L_VS_ON;
        // Undivided clock: de spans the whole active run; otherwise it marks the strobe clock.
        w_de     = w_active & ((CLK_DIV == 1) ? run : w_tick);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= 4'd0;
            r_hcnt    <= 11'd0;
            r_vcnt    <= 11'd0;
        end else if (w_tick) begin
            r_div_cnt <= 4'd0;
            if (r_hcnt == L_H_LAST) begin
                r_hcnt <= 11'd0;
                r_vcnt <= (r_vcnt == L_V_LAST) ? 11'd0 : r_vcnt + 11'd1;
            end else begin
                r_hcnt <= r_hcnt + 11'd1;
            end
        end else if (run) begin
            r_div_cnt <= r_div_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_c_en      <= 1'b0;
            r_h_c         <= 10'd0;
            r_v_c         <= 10'd0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_hs_raw      <= ~L_HS_ON;
            r_vs_raw      <= ~L_VS_ON;
            r_de_raw      <= 1'b0;
        end else begin
            r_h_c_en      <= w_h_c_en;
            r_h_c         <= w_h_act ? r_hcnt[9:0] : 10'd0;
            r_v_c         <= w_v_act ? r_vcnt[9:0] : 10'd0;
            r_frame_start <= run & (r_div_cnt == 4'd0) & (r_hcnt == 11'd0) & (r_vcnt == 11'd0);
            r_frame_end   <= w_h_c_en & (r_hcnt == L_H_XLAST) & (r_vcnt == L_V_YLAST);
            r_hs_raw      <= w_hs;
            r_vs_raw      <= w_vs;
            r_de_raw      <= w_de;
        end
    end

    assign h_c_en      = r_h_c_en;
    assign h_c         = r_h_c;
    assign v_c         = r_v_c;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;

    if (PIPE_LAT == 0) begin : g_direct
        assign hsync_o = r_hs_raw;
        assign vsync_o = r_vs_raw;
        assign de_o    = r_de_raw;
    end else begin : g_delay
        logic [2:0] r_dly [PIPE_LAT];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned i = 0; i < PIPE_LAT; i++) r_dly[i] <= L_IDLE;
            end else begin
                r_dly[0] <= {r_hs_raw, r_vs_raw, r_de_raw};
                for (int unsigned i = 1; i < PIPE_LAT; i++) r_dly[i] <= r_dly[i-1];
            end
        end

        assign {hsync_o, vsync_o, de_o} = r_dly[PIPE_LAT-1];
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three small-raster instances checked every clock against a queued
// reference model, plus phase table counts and hand-written corner-case sequences.
module tb_vga_timing_gen;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VA = 6;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic       en;
        logic [9:0] hc;
        logic [9:0] vc;
        logic       fs;
        logic       fe;
        logic       hs;
        logic       vs;
        logic       de;
    } out_t;

    typedef struct {
        int   cdiv;
        int   lat;
        logic hpol;
        logic vpol;
    } cfg_t;

    typedef struct {
        logic rst;
        logic run;
        int   cycles;
        int   exp_en;
        int   exp_fe;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic run;

    logic       en_w [3];
    logic [9:0] hc_w [3];
    logic [9:0] vc_w [3];
    logic       fs_w [3];
    logic       fe_w [3];
    logic       hs_w [3];
    logic       vs_w [3];
    logic       de_w [3];
    out_t       obs  [3];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1), .VS_POL(1), .CLK_DIV(1), .PIPE_LAT(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .run(run), .h_c_en(en_w[0]), .h_c(hc_w[0]), .v_c(vc_w[0]),
        .frame_start(fs_w[0]), .frame_end(fe_w[0]), .hsync_o(hs_w[0]), .vsync_o(vs_w[0]),
        .de_o(de_w[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(0), .VS_POL(1), .CLK_DIV(3), .PIPE_LAT(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .run(run), .h_c_en(en_w[1]), .h_c(hc_w[1]), .v_c(vc_w[1]),
        .frame_start(fs_w[1]), .frame_end(fe_w[1]), .hsync_o(hs_w[1]), .vsync_o(vs_w[1]),
        .de_o(de_w[1])
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1), .VS_POL(0), .CLK_DIV(2), .PIPE_LAT(0)
    ) u_dut_c (
        .clk(clk), .rst(rst), .run(run), .h_c_en(en_w[2]), .h_c(hc_w[2]), .v_c(vc_w[2]),
        .frame_start(fs_w[2]), .frame_end(fe_w[2]), .hsync_o(hs_w[2]), .vsync_o(vs_w[2]),
        .de_o(de_w[2])
    );

    for (genvar g = 0; g < 3; g++) begin : g_obs
        assign obs[g] = {en_w[g], hc_w[g], vc_w[g], fs_w[g], fe_w[g], hs_w[g], vs_w[g], de_w[g]};
    end

    cfg_t cfgs [3];
    int   m_div [3];
    int   m_x   [3];
    int   m_y   [3];
    logic [2:0] m_dly [3][8];
    out_t q0 [$];
    out_t q1 [$];
    out_t q2 [$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ph_en;
    int ph_fe;

    function automatic string fmt(input out_t o);
        return $sformatf("en=%b hc=%0d vc=%0d fs=%b fe=%b hs=%b vs=%b de=%b",
                         o.en, o.hc, o.vc, o.fs, o.fe, o.hs, o.vs, o.de);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input int k, input logic r, input logic rn, output out_t e);
        cfg_t c;
        logic act, tick;
        logic [2:0] idle, stage;
        c = cfgs[k];
        idle = {!c.hpol, !c.vpol, 1'b0};
        e = '0;
        if (r) begin
            m_div[k] = 0;
            m_x[k] = 0;
            m_y[k] = 0;
            for (int i = 0; i < 8; i++) m_dly[k][i] = idle;
            e.hs = !c.hpol;
            e.vs = !c.vpol;
        end else begin
            act  = (m_x[k] < HA) && (m_y[k] < VA);
            tick = rn && (m_div[k] == c.cdiv - 1);
            e.en = tick && act;
            e.hc = (m_x[k] < HA) ? 10'(m_x[k]) : 10'd0;
            e.vc = (m_y[k] < VA) ? 10'(m_y[k]) : 10'd0;
            e.fs = rn && (m_div[k] == 0) && (m_x[k] == 0) && (m_y[k] == 0);
            e.fe = e.en && (m_x[k] == HA - 1) && (m_y[k] == VA - 1);
            stage[2] = (m_x[k] >= HA + HF && m_x[k] < HA + HF + HS) ? c.hpol : !c.hpol;
            stage[1] = (m_y[k] >= VA + VF && m_y[k] < VA + VF + VS) ? c.vpol : !c.vpol;
            stage[0] = act && rn && ((c.cdiv == 1) || tick);
            for (int i = 7; i > 0; i--) m_dly[k][i] = m_dly[k][i-1];
            m_dly[k][0] = stage;
            {e.hs, e.vs, e.de} = m_dly[k][c.lat];
            if (tick) begin
                m_div[k] = 0;
                if (m_x[k] == HT - 1) begin
                    m_x[k] = 0;
                    m_y[k] = (m_y[k] == VT - 1) ? 0 : m_y[k] + 1;
                end else begin
                    m_x[k] = m_x[k] + 1;
                end
            end else if (rn) begin
                m_div[k] = m_div[k] + 1;
            end
        end
    endtask

    // One clock: queue the model's prediction for this edge, then compare after the edge.
    task automatic cycle();
        out_t e;
        for (int k = 0; k < 3; k++) begin
            model_step(k, rst, run, e);
            case (k)
                0: q0.push_back(e);
                1: q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            n_checks++;
            if (obs[k] !== e) begin
                n_errors++;
                $display("FAIL scoreboard dut%0d cycle %0d: actual %s required %s",
                         k, cyc, fmt(obs[k]), fmt(e));
            end
        end
        if (en_w[0]) ph_en++;
        if (fe_w[0]) ph_fe++;
        cyc++;
    endtask

    task automatic wait_a(input int want_hc, input int want_vc, input string name);
        int n = 0;
        while (!(en_w[0] === 1'b1 && (want_hc < 0 || int'(hc_w[0]) == want_hc) &&
                 (want_vc < 0 || int'(vc_w[0]) == want_vc))) begin
            if (n >= 400) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s: actual timeout required strobe within 400 clks", name);
                break;
            end
            cycle();
            n++;
        end
    endtask

    vec_t vecs [7];
    out_t idle_a;

    initial begin
        int fe_first, fe_second, fe_cnt, en_cnt, hs_first, hs_len, vs_first, vs_len;
        int fsb [2];
        int fsc [2];
        int nb, nc;
        logic hs_prev;

        cfgs[0] = '{cdiv: 1, lat: 1, hpol: 1'b1, vpol: 1'b1};
        cfgs[1] = '{cdiv: 3, lat: 2, hpol: 1'b0, vpol: 1'b1};
        cfgs[2] = '{cdiv: 2, lat: 0, hpol: 1'b1, vpol: 1'b0};
        idle_a = '0;

        vecs[0] = '{rst: 1'b1, run: 1'b1, cycles: 3,   exp_en: 0,  exp_fe: 0};
        vecs[1] = '{rst: 1'b0, run: 1'b1, cycles: 352, exp_en: 96, exp_fe: 2};
        vecs[2] = '{rst: 1'b0, run: 1'b0, cycles: 20,  exp_en: 0,  exp_fe: 0};
        vecs[3] = '{rst: 1'b0, run: 1'b1, cycles: 176, exp_en: 48, exp_fe: 1};
        vecs[4] = '{rst: 1'b1, run: 1'b0, cycles: 2,   exp_en: 0,  exp_fe: 0};
        vecs[5] = '{rst: 1'b0, run: 1'b1, cycles: 16,  exp_en: 8,  exp_fe: 0};
        vecs[6] = '{rst: 1'b0, run: 1'b1, cycles: 160, exp_en: 40, exp_fe: 1};

        rst = 1'b1;
        run = 1'b0;

        for (int v = 0; v < 7; v++) begin
            rst = vecs[v].rst;
            run = vecs[v].run;
            ph_en = 0;
            ph_fe = 0;
            for (int c = 0; c < vecs[v].cycles; c++) cycle();
            chk($sformatf("phase%0d_strobes", v), ph_en, vecs[v].exp_en);
            chk($sformatf("phase%0d_frame_end", v), ph_fe, vecs[v].exp_fe);
        end

        // Reset with run high: outputs idle, then pixel (0,0) on the first clock after release.
        rst = 1'b1;
        run = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("reset_idle", int'(obs[0]), int'(idle_a));
        end
        rst = 1'b0;
        fe_first = -1; fe_second = -1; fe_cnt = 0; en_cnt = 0;
        hs_first = -1; hs_len = 0; vs_first = -1; vs_len = 0;
        nb = 0; nc = 0; hs_prev = 1'b0;
        for (int i = 0; i < 1056; i++) begin
            cycle();
            if (i == 0) begin
                chk("first_en", int'(en_w[0]), 1);
                chk("first_hc", int'(hc_w[0]), 0);
                chk("first_vc", int'(vc_w[0]), 0);
                chk("first_fs", int'(fs_w[0]), 1);
            end
            if (i == 1) chk("de_lag", int'(de_w[0]), 1);
            if (en_w[0]) en_cnt++;
            if (fe_w[0]) begin
                fe_cnt++;
                if (fe_first < 0) fe_first = i;
                else if (fe_second < 0) fe_second = i;
                chk("fe_hc", int'(hc_w[0]), HA - 1);
                chk("fe_vc", int'(vc_w[0]), VA - 1);
            end
            if (hs_w[0] && !hs_prev && hs_first < 0) hs_first = i;
            if (i < HT && hs_w[0]) hs_len++;
            hs_prev = hs_w[0];
            if (vs_w[0] && vs_first < 0) vs_first = i;
            if (i < HT * VT && vs_w[0]) vs_len++;
            if (fs_w[1] && nb < 2) begin fsb[nb] = i; nb++; end
            if (fs_w[2] && nc < 2) begin fsc[nc] = i; nc++; end
        end
        chk("strobes_6_frames", en_cnt, 6 * HA * VA);
        chk("frame_end_count", fe_cnt, 6);
        chk("frame_end_first", fe_first, (VA - 1) * HT + HA - 1);
        chk("frame_end_period", fe_second - fe_first, HT * VT);
        chk("hsync_rise", hs_first, HA + HF + 1);
        chk("hsync_width", hs_len, HS);
        chk("vsync_rise", vs_first, (VA + VF) * HT + 1);
        chk("vsync_width", vs_len, VS * HT);
        chk("div3_frame_starts", nb, 2);
        chk("div3_frame_period", (nb == 2) ? fsb[1] - fsb[0] : -1, 3 * HT * VT);
        chk("div2_frame_starts", nc, 2);
        chk("div2_frame_period", (nc == 2) ? fsc[1] - fsc[0] : -1, 2 * HT * VT);

        // Freeze just before pixel 4 of a line, then resume without skipping it.
        wait_a(3, -1, "wait_hc3");
        run = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("frozen_en", int'(en_w[0]), 0);
            chk("frozen_hc", int'(hc_w[0]), 4);
        end
        run = 1'b1;
        cycle();
        chk("resume_en", int'(en_w[0]), 1);
        chk("resume_hc", int'(hc_w[0]), 4);
        cycle();
        chk("resume_next_en", int'(en_w[0]), 1);
        chk("resume_next_hc", int'(hc_w[0]), 5);

        // Reset mid-frame.
        wait_a(-1, 3, "wait_vc3");
        rst = 1'b1;
        cycle();
        chk("midframe_reset_idle", int'(obs[0]), int'(idle_a));
        rst = 1'b0;
        cycle();
        chk("restart_en", int'(en_w[0]), 1);
        chk("restart_hc", int'(hc_w[0]), 0);
        chk("restart_vc", int'(vc_w[0]), 0);
        chk("restart_fs", int'(fs_w[0]), 1);
        chk("restart_de_pending", int'(de_w[0]), 0);
        cycle();
        chk("restart_de_lag", int'(de_w[0]), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
